// File: rtl/m_d_rsp_tx_if.sv
// Response-transmitter port bundle: packet capture from memory, flit stream toward the cache ring.
// The slave side is the transmitter; the master side drives responses and flit_ready.
interface m_d_rsp_tx_if #(
  parameter int FLIT_W     = 16,
  parameter int LONG_FLITS = 11
);
  logic [FLIT_W*LONG_FLITS-1:0] mem_rsp_flits;
  logic                         v_mem_rsp;
  logic                         mem_rsp_short;
  logic                         flit_ready;
  logic [FLIT_W-1:0]            flit_out;
  logic                         v_flit_out;
  logic [1:0]                   flit_ctrl;
  logic                         m_d_tx_state;
  logic                         tx_done;

  modport master (
    output mem_rsp_flits, v_mem_rsp, mem_rsp_short, flit_ready,
    input  flit_out, v_flit_out, flit_ctrl, m_d_tx_state, tx_done
  );

  modport slave (
    input  mem_rsp_flits, v_mem_rsp, mem_rsp_short, flit_ready,
    output flit_out, v_flit_out, flit_ctrl, m_d_tx_state, tx_done
  );
endinterface

// File: rtl/m_d_rsp_tx.sv
// Memory response serializer: captures one packet, head flit valid the cycle after capture;
// flit_ready low holds the presented flit, and new responses are ignored while busy.
module m_d_rsp_tx #(
  parameter int FLIT_W      = 16,
  parameter int LONG_FLITS  = 11,
  parameter int SHORT_FLITS = 3
) (
  input  logic           clk,
  input  logic           rst,
  m_d_rsp_tx_if.slave    rsp
);
  localparam int PKT_W = FLIT_W * LONG_FLITS;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state;
  logic [PKT_W-1:0]   pkt;
  logic [3:0]         cnt;
  logic [3:0]         len;
  logic               done_q;
  logic               is_head;
  logic               is_tail;

  assign is_head = (cnt == 4'd0);
  assign is_tail = (cnt == len - 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pkt    <= '0;
      cnt    <= 4'd0;
      len    <= 4'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (rsp.v_mem_rsp) begin
          pkt   <= rsp.mem_rsp_flits;
          len   <= rsp.mem_rsp_short ? 4'(SHORT_FLITS) : 4'(LONG_FLITS);
          cnt   <= 4'd0;
          state <= SEND;
        end
      end else if (rsp.flit_ready) begin
        if (is_tail) begin
          // Clearing here keeps flit_out at zero through IDLE without extra gating state.
          state  <= IDLE;
          pkt    <= '0;
          cnt    <= 4'd0;
          done_q <= 1'b1;
        end else begin
          pkt <= {pkt[PKT_W-FLIT_W-1:0], {FLIT_W{1'b0}}};
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

  assign rsp.v_flit_out   = (state == SEND);
  assign rsp.m_d_tx_state = (state == SEND);
  assign rsp.flit_out     = (state == SEND) ? pkt[PKT_W-1 -: FLIT_W] : '0;
  assign rsp.flit_ctrl    = (state != SEND) ? 2'b00 :
                            is_head         ? 2'b01 :
                            is_tail         ? 2'b10 : 2'b00;
  assign rsp.tx_done      = done_q;
endmodule

// File: doc/m_d_rsp_tx.md
# m_d_rsp_tx

Memory-side response transmitter for the data path between memory and the data cache. It sits at the memory end of the ring node's communication assist and captures one completed memory response packet, up to 176 bits. It then serializes that packet into 16-bit flits toward the data-cache/ring side under a ready/valid handshake. It is the return direction of the data-to-memory access register: that block delivers requests to memory, and this block carries the replies back.

## Interface
Parameters:
- FLIT_W, 16, flit width in bits.
- LONG_FLITS, 11, flits in a data-carrying reply (header + cache line); packet register width = FLIT_W*LONG_FLITS = 176.
- SHORT_FLITS, 3, flits in a header-only reply (write ack / invalidate ack).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_rsp_flits  in  176  response packet; flit 0 (head) in [175:160], flit k in [175-16k:160-16k].
- v_mem_rsp  in  1  response valid; accepted only when m_d_tx_state=0.
- mem_rsp_short  in  1  sampled with v_mem_rsp; 1 = SHORT_FLITS packet, 0 = LONG_FLITS packet.
- flit_ready  in  1  downstream accepts the presented flit this cycle.
- flit_out  out  16  current flit.
- v_flit_out  out  1  flit_out valid.
- flit_ctrl  out  2  2'b01 head, 2'b00 body, 2'b10 tail; 2'b11 never driven.
- m_d_tx_state  out  1  busy; 1 = packet held/in transmission, new responses not accepted.
- tx_done  out  1  one-cycle pulse after the tail flit is accepted.

## Operation
- States: IDLE, SEND.
- IDLE:
  - If v_mem_rsp=1, load the packet register with mem_rsp_flits.
  - Latch len = mem_rsp_short ? 3 : 11, and clear the 4-bit flit counter cnt.
  - Go to SEND.
- SEND:
  - Outputs: v_flit_out=1, flit_out = register[175:160].
  - flit_ctrl = 01 when cnt=0, 10 when cnt=len-1, 00 otherwise.
- Handshake: a transfer occurs only in a cycle with v_flit_out=1 and flit_ready=1.
  - On a non-tail transfer: shift the register left by FLIT_W (zero fill) and increment cnt.
  - On the tail transfer (cnt=len-1): go to IDLE, clear the register, set tx_done=1 for the next cycle.
- Backpressure: while flit_ready=0, flit_out, flit_ctrl, cnt and the register hold unchanged. The flit is never dropped or duplicated.
- m_d_tx_state = 1 exactly when state=SEND.
- In IDLE, v_flit_out=0, flit_out=0 and flit_ctrl=00.
- v_mem_rsp while busy is ignored: no capture, no state change. The memory side must gate on m_d_tx_state.
- mem_rsp_short and mem_rsp_flits are don't-care when v_mem_rsp=0.
- Short packet: only flits 0..2 are sent; register bits below [127:0] are discarded.

## Timing
- Reset values: state IDLE, register 0, cnt 0, v_flit_out 0, flit_out 0, flit_ctrl 00, m_d_tx_state 0, tx_done 0.
- rst has priority over every other input. Reset mid-packet aborts the packet with no tail and no tx_done, and the block is IDLE next cycle.
- Capture latency: v_mem_rsp sampled at edge N → head flit valid in cycle N+1.
- With flit_ready held at 1, flits occupy cycles N+1..N+len, and tx_done=1 with m_d_tx_state=0 in cycle N+len+1.
- Simultaneous events: v_mem_rsp=1 in the tx_done cycle is accepted, since the block is IDLE. Back-to-back throughput is therefore one packet per len+1 cycles.
- flit_ready is ignored in IDLE.
- cnt never exceeds len-1, and there is no wrap-around.

## Test plan
- Reset: assert rst 2 cycles with random inputs → all outputs 0 during reset and the cycle after.
- Long packet: mem_rsp_flits = 0x0001_0002_…_000B, short=0, flit_ready=1 → flits 0x0001..0x000B on cycles 1..11, ctrl 01, then 00×9, then 10; tx_done on cycle 12.
- Short packet: the same data with short=1 → flits 0x0001, 0x0002, 0x0003 with ctrl 01/00/10; tx_done on cycle 4; flit_out=0 afterwards.
- Backpressure: long packet with flit_ready toggling 1,0,0,1,… → each flit held stable while ready=0; the sequence 0x0001..0x000B is intact, and tx_done follows the 11th accepted transfer.
- Busy and back-to-back:
  - Issue v_mem_rsp with a different pattern mid-packet → the pattern is ignored and the first packet completes unaltered.
  - Issue a new v_mem_rsp in the tx_done cycle → its head appears the next cycle.
- Reset mid-packet: assert rst after flit 5 → v_flit_out=0 and no tx_done. A new packet issued afterwards starts cleanly with a head flit.
